// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM states, abort causes and fun3 encodings for the load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR} lsu_state_e;
    typedef enum logic [1:0] {C_NONE, C_MISALIGN, C_ILLEGAL, C_TIMEOUT} lsu_cause_e;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Stores only know sb/sh/sw; loads additionally accept the unsigned forms.
    function automatic logic fun3_illegal(input logic we, input logic [2:0] f);
        return we ? (f > F3_W) : !(f inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for stores, extract/extend for loads, and the alignment check.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_fun3_i,
    input  logic [1:0]  st_addr_i,
    input  logic [31:0] st_wdata_i,
    input  logic [2:0]  ld_fun3_i,
    input  logic [1:0]  ld_addr_i,
    input  logic [31:0] ld_rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o,
    output logic [31:0] ld_data_o
);

    logic [1:0]  sz;
    logic [31:0] w;

    // Low two fun3 bits give the access size for both loads and stores.
    always_comb begin
        sz         = st_fun3_i[1:0];
        be_o       = sz == 2'd0 ? 4'b0001 << st_addr_i :
                     sz == 2'd1 ? 4'b0011 << {st_addr_i[1], 1'b0} : 4'b1111;
        wdata_o    = sz == 2'd0 ? {4{st_wdata_i[7:0]}} :
                     sz == 2'd1 ? {2{st_wdata_i[15:0]}} : st_wdata_i;
        misalign_o = (sz == 2'd1 && st_addr_i[0]) || (sz == 2'd2 && st_addr_i != 2'd0);
        w          = ld_rdata_i >> {ld_addr_i, 3'b000};
        ld_data_o  = ld_fun3_i == F3_B  ? {{24{w[7]}}, w[7:0]} :
                     ld_fun3_i == F3_BU ? {24'd0, w[7:0]} :
                     ld_fun3_i == F3_H  ? {{16{w[15]}}, w[15:0]} :
                     ld_fun3_i == F3_HU ? {16'd0, w[15:0]} : w;
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer driving the req/gnt/rvalid data-memory handshake.
// Latches the access in IDLE, retires it with a valid pulse or aborts it with an error pulse.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lsu_rd_i,
    input  logic          lsu_wr_i,
    input  logic [2:0]    lsu_fun3_i,
    input  logic [AW-1:0] lsu_addr_i,
    input  logic [DW-1:0] lsu_wdata_i,
    output logic          lsu_stall_o,
    output logic          lsu_valid_o,
    output logic [DW-1:0] lsu_rdata_o,
    output logic          lsu_err_o,
    output logic [1:0]    lsu_err_cause_o,
    output logic          dmem_req_o,
    output logic          dmem_we_o,
    output logic [3:0]    dmem_be_o,
    output logic [AW-1:0] dmem_addr_o,
    output logic [DW-1:0] dmem_wdata_o,
    input  logic          dmem_gnt_i,
    input  logic          dmem_rvalid_i,
    input  logic [DW-1:0] dmem_rdata_i
);

    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_e    state_q, state_d;
    lsu_cause_e    cause_q, cause_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    fun3_q, fun3_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [3:0]    al_be;
    logic [DW-1:0] al_wdata, al_ld;
    logic          al_misalign, tout, req_any;

    lsu_align u_align (
        .st_fun3_i  (lsu_fun3_i),
        .st_addr_i  (lsu_addr_i[1:0]),
        .st_wdata_i (lsu_wdata_i),
        .ld_fun3_i  (fun3_q),
        .ld_addr_i  (addr_q[1:0]),
        .ld_rdata_i (dmem_rdata_i),
        .be_o       (al_be),
        .wdata_o    (al_wdata),
        .misalign_o (al_misalign),
        .ld_data_o  (al_ld)
    );

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        addr_d      = addr_q;
        fun3_d      = fun3_q;
        we_d        = we_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        lsu_stall_o = 1'b0;
        req_any     = lsu_rd_i | lsu_wr_i;
        // Abort on the cycle whose increment would reach the limit, so req stays up exactly TIMEOUT cycles.
        tout        = TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1);
        case (state_q)
            S_IDLE: if (req_any) begin
                lsu_stall_o = 1'b1;
                addr_d      = lsu_addr_i;
                fun3_d      = lsu_fun3_i;
                we_d        = lsu_wr_i;
                be_d        = al_be;
                wdata_d     = al_wdata;
                cnt_d       = '0;
                cause_d     = (lsu_rd_i & lsu_wr_i) || fun3_illegal(lsu_wr_i, lsu_fun3_i) ? C_ILLEGAL :
                              al_misalign ? C_MISALIGN : C_NONE;
                state_d     = cause_d == C_NONE ? S_REQ : S_ERR;
            end
            S_REQ: begin
                lsu_stall_o = 1'b1;
                cnt_d       = cnt_q + CW'(1);
                if (dmem_gnt_i) begin
                    cnt_d   = '0;
                    state_d = dmem_rvalid_i ? S_DONE : S_WAIT;
                    rdata_d = dmem_rvalid_i ? (we_q ? '0 : al_ld) : rdata_q;
                end else if (tout) begin
                    state_d = S_ERR;
                    cause_d = C_TIMEOUT;
                end
            end
            S_WAIT: begin
                lsu_stall_o = 1'b1;
                cnt_d       = cnt_q + CW'(1);
                if (dmem_rvalid_i) begin
                    state_d = S_DONE;
                    rdata_d = we_q ? '0 : al_ld;
                end else if (tout) begin
                    state_d = S_ERR;
                    cause_d = C_TIMEOUT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cause_q <= C_NONE;
            addr_q  <= '0;
            fun3_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            addr_q  <= addr_d;
            fun3_q  <= fun3_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign lsu_valid_o     = state_q == S_DONE;
    assign lsu_err_o       = state_q == S_ERR;
    assign lsu_err_cause_o = state_q == S_ERR ? cause_q : C_NONE;
    assign lsu_rdata_o     = rdata_q;
    assign dmem_req_o      = state_q == S_REQ;
    assign dmem_we_o       = we_q;
    assign dmem_be_o       = be_q;
    assign dmem_addr_o     = {addr_q[AW-1:2], 2'b00};
    assign dmem_wdata_o    = wdata_q;

endmodule
